// File: rtl/k_sequencer_if.sv
// Handshake bundle between the round-constant sequencer and its consumer.
// The sequencer sits on the master side and drives the constant stream.
// The consumer (hash core) sits on the slave side and drives start/abort/k_ready.
interface k_sequencer_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic              abort;
  logic              k_ready;
  logic              k_valid;
  logic [WORD_W-1:0] k_word;
  logic [6:0]        k_round;
  logic              k_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, k_ready,
    output k_valid, k_word, k_round, k_last, busy, done
  );

  modport slave (
    output start, abort, k_ready,
    input  k_valid, k_word, k_round, k_last, busy, done
  );
endinterface

// File: rtl/k_sequencer.sv
// SHA-2 round-constant sequencer.
// On start it streams K[0..ROUNDS-1] over a valid/ready handshake, then pulses
// done for one cycle. All outputs are registered. The round register doubles
// as the sequence counter.
module k_sequencer #(
  parameter int WORD_W = 32
) (
  input logic            clk,
  input logic            rst,
  k_sequencer_if.master  bus
);

  localparam int         ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST   = 7'(ROUNDS - 1);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("k_sequencer: WORD_W must be 32 or 64");
    end
  endgenerate

  // SHA-384/512 constants. The SHA-224/256 constants are exactly the upper
  // 32 bits of the first 64 entries, so a single table serves both widths.
  localparam logic [63:0] K_TAB [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  // Constant for a given round, truncated to the configured word width.
  function automatic logic [WORD_W-1:0] k_at(input logic [6:0] idx);
    return K_TAB[idx][63 -: WORD_W];
  endfunction

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.k_valid <= 1'b0;
      bus.k_word  <= '0;
      bus.k_round <= '0;
      bus.k_last  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          // abort has no meaning here, so start alone decides
          if (bus.start) begin
            state       <= RUN;
            bus.k_valid <= 1'b1;
            bus.k_word  <= k_at(7'd0);
            bus.k_round <= 7'd0;
            bus.k_last  <= (LAST == 7'd0);
            bus.busy    <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.k_valid <= 1'b0;
            bus.k_word  <= '0;
            bus.k_round <= 7'd0;
            bus.k_last  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
          end else if (bus.k_ready) begin
            if (bus.k_round == LAST) begin
              // final handshake: the counter resets here instead of wrapping
              state       <= DONE;
              bus.k_valid <= 1'b0;
              bus.k_word  <= '0;
              bus.k_round <= 7'd0;
              bus.k_last  <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              bus.k_round <= bus.k_round + 7'd1;
              bus.k_word  <= k_at(bus.k_round + 7'd1);
              bus.k_last  <= ((bus.k_round + 7'd1) == LAST);
            end
          end
        end
        DONE: begin
          // single-cycle state; start is ignored and abort lands in IDLE too
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          bus.k_valid <= 1'b0;
          bus.k_word  <= '0;
          bus.k_round <= 7'd0;
          bus.k_last  <= 1'b0;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k_sequencer.sv
// Directed bench for k_sequencer: one 32-bit and one 64-bit instance, with
// known FIPS 180-4 constants at selected rounds as the expected values.
`timescale 1ns/1ps
module tb_k_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  k_sequencer_if #(.WORD_W(32)) b32 ();
  k_sequencer_if #(.WORD_W(64)) b64 ();

  k_sequencer #(.WORD_W(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  k_sequencer #(.WORD_W(64)) u64 (.clk(clk), .rst(rst), .bus(b64));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Outputs of the 32-bit instance when it is idle.
  task automatic idle32(input string tag);
    check({tag, "_valid"}, 64'(b32.k_valid), 64'd0);
    check({tag, "_word"},  64'(b32.k_word),  64'd0);
    check({tag, "_busy"},  64'(b32.busy),    64'd0);
    check({tag, "_done"},  64'(b32.done),    64'd0);
  endtask

  logic [31:0] held;
  bit          stalled;
  bit          fin;
  bit          r;
  int          exp_r;

  initial begin
    rst = 1'b1;
    b32.start = 1'b0; b32.abort = 1'b0; b32.k_ready = 1'b1;
    b64.start = 1'b0; b64.abort = 1'b0; b64.k_ready = 1'b1;
    repeat (2) @(negedge clk);

    // reset state, both widths
    idle32("rst32");
    check("rst32_round", 64'(b32.k_round), 64'd0);
    check("rst32_last",  64'(b32.k_last),  64'd0);
    check("rst64_valid", 64'(b64.k_valid), 64'd0);
    check("rst64_word",  b64.k_word,       64'd0);
    check("rst64_round", 64'(b64.k_round), 64'd0);
    check("rst64_busy",  64'(b64.busy),    64'd0);
    check("rst64_done",  64'(b64.done),    64'd0);
    rst = 1'b0;
    @(negedge clk);
    idle32("post_rst");

    // full 32-bit run, ready tied high; a stray start at round 5 is ignored
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check("t1_valid", 64'(b32.k_valid), 64'd1);
      check("t1_round", 64'(b32.k_round), 64'(i));
      check("t1_last",  64'(b32.k_last),  64'(i == 63));
      check("t1_busy",  64'(b32.busy),    64'd1);
      check("t1_done",  64'(b32.done),    64'd0);
      if (i == 0)  check("t1_k0",  64'(b32.k_word), 64'h428a2f98);
      if (i == 1)  check("t1_k1",  64'(b32.k_word), 64'h71374491);
      if (i == 10) check("t1_k10", 64'(b32.k_word), 64'h243185be);
      if (i == 63) check("t1_k63", 64'(b32.k_word), 64'hc67178f2);
      b32.start = (i == 5);
      @(negedge clk);
    end
    b32.start = 1'b0;
    check("t1_done_pulse", 64'(b32.done),    64'd1);
    check("t1_done_valid", 64'(b32.k_valid), 64'd0);
    check("t1_done_word",  64'(b32.k_word),  64'd0);
    check("t1_done_busy",  64'(b32.busy),    64'd1);
    // start during DONE is ignored; held into the following IDLE it starts anew
    b32.start = 1'b1;
    @(negedge clk);
    idle32("t1_after_done");
    @(negedge clk);
    b32.start = 1'b0;
    check("t1_restart_valid", 64'(b32.k_valid), 64'd1);
    check("t1_restart_round", 64'(b32.k_round), 64'd0);
    check("t1_restart_k0",    64'(b32.k_word),  64'h428a2f98);

    // abort at round 10
    repeat (10) @(negedge clk);
    check("ab_round", 64'(b32.k_round), 64'd10);
    check("ab_k10",   64'(b32.k_word),  64'h243185be);
    b32.abort = 1'b1;
    @(negedge clk);
    b32.abort = 1'b0;
    idle32("ab_next");
    check("ab_round0", 64'(b32.k_round), 64'd0);
    @(negedge clk);
    idle32("ab_later");
    // start together with abort in IDLE: start wins
    b32.start = 1'b1;
    b32.abort = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    b32.abort = 1'b0;
    check("ab_restart_valid", 64'(b32.k_valid), 64'd1);
    check("ab_restart_round", 64'(b32.k_round), 64'd0);
    check("ab_restart_k0",    64'(b32.k_word),  64'h428a2f98);

    // asynchronous reset mid-cycle at round 30
    repeat (30) @(negedge clk);
    check("ar_round", 64'(b32.k_round), 64'd30);
    check("ar_k30",   64'(b32.k_word),  64'h06ca6351);
    #2 rst = 1'b1;
    #1;
    idle32("ar_async");
    check("ar_async_round", 64'(b32.k_round), 64'd0);
    check("ar_async_last",  64'(b32.k_last),  64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idle32("ar_release");
    @(negedge clk);
    idle32("ar_no_done");
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    check("ar_restart_round", 64'(b32.k_round), 64'd0);
    check("ar_restart_k0",    64'(b32.k_word),  64'h428a2f98);

    // backpressure with random ready; round 0 is stalled deliberately
    exp_r   = 0;
    stalled = 1'b0;
    fin     = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      check("bp_valid", 64'(b32.k_valid), 64'd1);
      check("bp_round", 64'(b32.k_round), 64'(exp_r));
      if (stalled) check("bp_hold", 64'(b32.k_word), 64'(held));
      if (exp_r == 0) check("bp_k0", 64'(b32.k_word), 64'h428a2f98);
      if (exp_r == 1) check("bp_k1", 64'(b32.k_word), 64'h71374491);
      held = b32.k_word;
      r = ($urandom_range(0, 1) == 1);
      if (c < 2) r = 1'b0;
      b32.k_ready = r;
      @(negedge clk);
      stalled = !r;
      if (r) begin
        exp_r++;
        if (exp_r == 64) fin = 1'b1;
      end
    end
    b32.k_ready = 1'b1;
    check("bp_complete", 64'(fin),          64'd1);
    check("bp_done",     64'(b32.done),     64'd1);
    check("bp_valid_end", 64'(b32.k_valid), 64'd0);

    // full 64-bit run, ready tied high
    b64.start = 1'b1;
    @(negedge clk);
    b64.start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      check("t64_valid", 64'(b64.k_valid), 64'd1);
      check("t64_round", 64'(b64.k_round), 64'(i));
      check("t64_last",  64'(b64.k_last),  64'(i == 79));
      if (i == 0)  check("t64_k0",  b64.k_word, 64'h428a2f98d728ae22);
      if (i == 1)  check("t64_k1",  b64.k_word, 64'h7137449123ef65cd);
      if (i == 63) check("t64_k63", b64.k_word, 64'hc67178f2e372532b);
      if (i == 79) check("t64_k79", b64.k_word, 64'h6c44198c4a475817);
      @(negedge clk);
    end
    check("t64_done_pulse", 64'(b64.done),    64'd1);
    check("t64_done_valid", 64'(b64.k_valid), 64'd0);
    @(negedge clk);
    check("t64_idle_done", 64'(b64.done), 64'd0);
    check("t64_idle_busy", 64'(b64.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
